// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Optional starvation guard is enabled by defining DMEM_ARB_STARVE_EN.
package dmem_arbiter_pkg;

    localparam int AW_DEF       = 10;
    localparam int MAX_WAIT_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CPU  = 2'd1,
        ST_DBG  = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } owner_e;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter (CPU MEM stage over debug/loader) for the single-port d_mem.
// Define DMEM_ARB_STARVE_EN to bound how long debug can be denied by the CPU.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic          clk1,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [31:0]   cpu_addr,
    input  logic [31:0]   cpu_wdata,
    input  logic [3:0]    cpu_be,
    output logic          cpu_gnt,
    output logic          cpu_stall,
    output logic          cpu_rvalid,
    output logic [31:0]   cpu_rdata,
    input  logic          dbg_req,
    input  logic          dbg_lock,
    input  logic          dbg_we,
    input  logic [31:0]   dbg_addr,
    input  logic [31:0]   dbg_wdata,
    input  logic [3:0]    dbg_be,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    output logic [31:0]   dbg_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    input  logic [31:0]   mem_rdata
);

    arb_state_e  state_q, state_d;
    owner_e      resp_owner_q, resp_owner_d;
    logic [31:0] cpu_rdata_q, cpu_rdata_d;
    logic [31:0] dbg_rdata_q, dbg_rdata_d;
    logic        starve_force;

`ifdef DMEM_ARB_STARVE_EN
    localparam int WCW = $clog2(MAX_WAIT + 1);
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;

    assign starve_force = dbg_req && (wait_cnt_q == WCW'(MAX_WAIT));

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (dbg_gnt)
            wait_cnt_d = '0;
        else if (dbg_req && (wait_cnt_q != WCW'(MAX_WAIT)))
            wait_cnt_d = wait_cnt_q + 1'b1;
    end

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) wait_cnt_q <= '0;
        else      wait_cnt_q <= wait_cnt_d;
    end
`else
    logic unused_max_wait;
    assign unused_max_wait = (MAX_WAIT != 0);
    assign starve_force    = 1'b0;
`endif

    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[31:AW+2], cpu_addr[1:0],
                                dbg_addr[31:AW+2], dbg_addr[1:0]};

    // Grants are forced low while reset is held so nothing reaches d_mem mid-reset.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise an uncovered branch infers a latch.
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (rst) begin
            if ((state_q == ST_DBG && dbg_req && dbg_lock) || starve_force)
                dbg_gnt = 1'b1;
            else if (cpu_req)
                cpu_gnt = 1'b1;
            else if (dbg_req)
                dbg_gnt = 1'b1;
        end
    end

    assign cpu_stall = cpu_req & ~cpu_gnt;
    assign mem_en    = cpu_gnt | dbg_gnt;

    always_comb begin
        mem_we    = cpu_gnt & cpu_we;
        mem_addr  = cpu_addr[AW+1:2];
        mem_wdata = cpu_wdata;
        mem_be    = cpu_be;
        if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr[AW+1:2];
            mem_wdata = dbg_wdata;
            mem_be    = dbg_be;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        if (dbg_gnt && dbg_lock) state_d = ST_DBG;
        else if (cpu_gnt)        state_d = ST_CPU;

        resp_owner_d = OWN_NONE;
        if (mem_en && !mem_we) resp_owner_d = cpu_gnt ? OWN_CPU : OWN_DBG;
    end

    // Read data is a live view of mem_rdata in the response cycle, then held.
    assign cpu_rvalid = (resp_owner_q == OWN_CPU);
    assign dbg_rvalid = (resp_owner_q == OWN_DBG);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : dbg_rdata_q;
    assign cpu_rdata_d = cpu_rdata;
    assign dbg_rdata_d = dbg_rdata;

    always_ff @(posedge clk1 or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (!rst) begin
            state_q      <= ST_IDLE;
            resp_owner_q <= OWN_NONE;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            resp_owner_q <= resp_owner_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous d_mem model.
module tb_dmem_arbiter;

    localparam int AW = 10;

    logic          clk1 = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we;
    logic [31:0]   cpu_addr, cpu_wdata;
    logic [3:0]    cpu_be;
    logic          cpu_gnt, cpu_stall, cpu_rvalid;
    logic [31:0]   cpu_rdata;
    logic          dbg_req, dbg_lock, dbg_we;
    logic [31:0]   dbg_addr, dbg_wdata;
    logic [3:0]    dbg_be;
    logic          dbg_gnt, dbg_rvalid;
    logic [31:0]   dbg_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic [31:0]   mem_rdata;

    logic [31:0]   d_mem [0:(1<<AW)-1];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk1 = ~clk1;

    dmem_arbiter #(.AW(AW), .MAX_WAIT(8)) dut (
        .clk1(clk1), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_lock(dbg_lock), .dbg_we(dbg_we),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_be(dbg_be),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    // Word 0 preloads to zero, every other word to 0x1000_0000 + index.
    always @(posedge clk1) begin
        if (!rst) begin
            for (int i = 0; i < (1 << AW); i++)
                d_mem[i] <= (i == 0) ? 32'h0 : 32'h1000_0000 + i;
            mem_rdata <= 32'h0;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) d_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= d_mem[mem_addr];
            end
        end
    end

    task automatic set_cpu(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
        cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
    endtask

    task automatic set_dbg(input logic req, input logic lock, input logic we,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be);
        dbg_req = req; dbg_lock = lock; dbg_we = we;
        dbg_addr = addr; dbg_wdata = wdata; dbg_be = be;
    endtask

    task automatic test_reset;
        set_cpu(1'b1, 1'b0, 32'h10, 32'h0, 4'hf);
        set_dbg(1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 4'hf);
        #2;
        n_cmp++; if (cpu_gnt !== 1'b0) begin n_err++; $display("FAIL reset_cpu_gnt: got %b want 0", cpu_gnt); end
        n_cmp++; if (dbg_gnt !== 1'b0) begin n_err++; $display("FAIL reset_dbg_gnt: got %b want 0", dbg_gnt); end
        n_cmp++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
        n_cmp++; if (cpu_rvalid !== 1'b0 || dbg_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got %b%b want 00", cpu_rvalid, dbg_rvalid); end
        n_cmp++; if (cpu_rdata !== 32'h0 || dbg_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h/%h want 0/0", cpu_rdata, dbg_rdata); end
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_dbg(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk1); rst = 1'b1; #2;
        n_cmp++; if (mem_en !== 1'b0) begin n_err++; $display("FAIL post_reset_mem_en: got %b want 0", mem_en); end
    endtask

    task automatic test_byte_enable;
        @(negedge clk1);
        set_dbg(1'b1, 1'b0, 1'b1, 32'h0, 32'h1122_3344, 4'b0101); #2;
        n_cmp++; if (dbg_gnt !== 1'b1 || mem_we !== 1'b1) begin n_err++; $display("FAIL be_grant: got gnt=%b we=%b want 1/1", dbg_gnt, mem_we); end
        n_cmp++; if (mem_be !== 4'b0101 || mem_addr !== 10'd0) begin n_err++; $display("FAIL be_mem_fields: got be=%b addr=%0d want 0101/0", mem_be, mem_addr); end
        @(negedge clk1);
        set_dbg(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #2;
        n_cmp++; if (d_mem[0] !== 32'h0022_0044) begin n_err++; $display("FAIL be_result: got %h want 00220044", d_mem[0]); end
        n_cmp++; if (dbg_rvalid !== 1'b0) begin n_err++; $display("FAIL be_no_rvalid: got %b want 0", dbg_rvalid); end
    endtask

    task automatic test_contention;
        @(negedge clk1);
        set_cpu(1'b1, 1'b0, 32'h10, 32'h0, 4'hf);
        set_dbg(1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 4'hf); #2;
        n_cmp++; if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin n_err++; $display("FAIL cont_gnt: got cpu=%b dbg=%b want 1/0", cpu_gnt, dbg_gnt); end
        n_cmp++; if (cpu_stall !== 1'b0) begin n_err++; $display("FAIL cont_stall: got %b want 0", cpu_stall); end
        n_cmp++; if (mem_addr !== 10'd4) begin n_err++; $display("FAIL cont_addr: got %0d want 4", mem_addr); end
        @(negedge clk1);
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #2;
        n_cmp++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h1000_0004) begin n_err++; $display("FAIL cont_cpu_read: got v=%b d=%h want 1/10000004", cpu_rvalid, cpu_rdata); end
        n_cmp++; if (dbg_gnt !== 1'b1 || mem_addr !== 10'd8) begin n_err++; $display("FAIL cont_dbg_late: got gnt=%b addr=%0d want 1/8", dbg_gnt, mem_addr); end
        @(negedge clk1);
        set_dbg(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #2;
        n_cmp++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'h1000_0008) begin n_err++; $display("FAIL cont_dbg_read: got v=%b d=%h want 1/10000008", dbg_rvalid, dbg_rdata); end
        n_cmp++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h1000_0004) begin n_err++; $display("FAIL cont_cpu_hold: got v=%b d=%h want 0/10000004", cpu_rvalid, cpu_rdata); end
    endtask

    task automatic test_debug_lock;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk1);
            set_dbg(1'b1, 1'b1, 1'b1, 32'(4 * i), 32'habcd_ef12, 4'hf);
            set_cpu(i > 0, 1'b0, 32'h40, 32'h0, 4'hf); #2;
            n_cmp++; if (dbg_gnt !== 1'b1 || cpu_gnt !== 1'b0) begin n_err++; $display("FAIL lock_gnt[%0d]: got dbg=%b cpu=%b want 1/0", i, dbg_gnt, cpu_gnt); end
            n_cmp++; if (cpu_stall !== (i > 0)) begin n_err++; $display("FAIL lock_stall[%0d]: got %b want %b", i, cpu_stall, (i > 0)); end
            n_cmp++; if (mem_wdata !== 32'habcd_ef12 || mem_addr !== 10'(i)) begin n_err++; $display("FAIL lock_mem[%0d]: got %h@%0d want abcdef12@%0d", i, mem_wdata, mem_addr, i); end
        end
        @(negedge clk1);
        set_dbg(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #2;
        n_cmp++; if (cpu_gnt !== 1'b1 || cpu_stall !== 1'b0) begin n_err++; $display("FAIL lock_release: got gnt=%b stall=%b want 1/0", cpu_gnt, cpu_stall); end
        n_cmp++; if (dbg_rvalid !== 1'b0) begin n_err++; $display("FAIL lock_no_rvalid: got %b want 0", dbg_rvalid); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (d_mem[i] !== 32'habcd_ef12) begin n_err++; $display("FAIL lock_data[%0d]: got %h want abcdef12", i, d_mem[i]); end
        end
    endtask

    task automatic test_starvation;
        int grants;
        @(negedge clk1);
        set_cpu(1'b1, 1'b0, 32'h40, 32'h0, 4'hf);
        set_dbg(1'b1, 1'b0, 1'b0, 32'h44, 32'h0, 4'hf);
`ifdef DMEM_ARB_STARVE_EN
        for (int c = 1; c <= 10; c++) begin
            if (c > 1) @(negedge clk1);
            #2;
            n_cmp++; if (dbg_gnt !== (c == 9)) begin n_err++; $display("FAIL starve_gnt[cycle %0d]: got %b want %b", c, dbg_gnt, (c == 9)); end
            n_cmp++; if (cpu_stall !== (c == 9)) begin n_err++; $display("FAIL starve_stall[cycle %0d]: got %b want %b", c, cpu_stall, (c == 9)); end
        end
`else
        grants = 0;
        for (int c = 1; c <= 50; c++) begin
            if (c > 1) @(negedge clk1);
            #2;
            if (dbg_gnt === 1'b1) grants++;
        end
        n_cmp++; if (grants != 0) begin n_err++; $display("FAIL starve_never: got %0d dbg grants want 0", grants); end
`endif
        @(negedge clk1);
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #2;
        n_cmp++; if (dbg_gnt !== 1'b1) begin n_err++; $display("FAIL starve_drain: got %b want 1", dbg_gnt); end
        @(negedge clk1);
        set_dbg(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic test_alternation;
        @(negedge clk1);
        set_cpu(1'b1, 1'b0, 32'h10, 32'h0, 4'hf); #2;
        n_cmp++; if (cpu_gnt !== 1'b1) begin n_err++; $display("FAIL alt_cpu_gnt: got %b want 1", cpu_gnt); end
        @(negedge clk1);
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_dbg(1'b1, 1'b0, 1'b0, 32'h24, 32'h0, 4'hf); #2;
        n_cmp++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h1000_0004) begin n_err++; $display("FAIL alt_cpu_1: got v=%b d=%h want 1/10000004", cpu_rvalid, cpu_rdata); end
        n_cmp++; if (dbg_gnt !== 1'b1) begin n_err++; $display("FAIL alt_dbg_gnt: got %b want 1", dbg_gnt); end
        @(negedge clk1);
        set_dbg(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_cpu(1'b1, 1'b0, 32'h30, 32'h0, 4'hf); #2;
        n_cmp++; if (dbg_rvalid !== 1'b1 || dbg_rdata !== 32'h1000_0009) begin n_err++; $display("FAIL alt_dbg: got v=%b d=%h want 1/10000009", dbg_rvalid, dbg_rdata); end
        n_cmp++; if (cpu_rvalid !== 1'b0) begin n_err++; $display("FAIL alt_cpu_gap: got %b want 0", cpu_rvalid); end
        @(negedge clk1);
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0, 4'h0); #2;
        n_cmp++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h1000_000c) begin n_err++; $display("FAIL alt_cpu_2: got v=%b d=%h want 1/1000000c", cpu_rvalid, cpu_rdata); end
        n_cmp++; if (dbg_rvalid !== 1'b0 || dbg_rdata !== 32'h1000_0009) begin n_err++; $display("FAIL alt_dbg_hold: got v=%b d=%h want 0/10000009", dbg_rvalid, dbg_rdata); end
    endtask

    task automatic test_reset_mid_access;
        @(negedge clk1);
        set_dbg(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'hf); #2;
        n_cmp++; if (dbg_gnt !== 1'b1) begin n_err++; $display("FAIL mid_setup_gnt: got %b want 1", dbg_gnt); end
        @(posedge clk1); #1;
        rst = 1'b0; #1;
        n_cmp++; if (dbg_rvalid !== 1'b0) begin n_err++; $display("FAIL mid_rvalid_drop: got %b want 0", dbg_rvalid); end
        n_cmp++; if (dbg_gnt !== 1'b0 || mem_en !== 1'b0) begin n_err++; $display("FAIL mid_gnt: got gnt=%b en=%b want 0/0", dbg_gnt, mem_en); end
        n_cmp++; if (dbg_rdata !== 32'h0) begin n_err++; $display("FAIL mid_rdata: got %h want 0", dbg_rdata); end
        @(negedge clk1);
        rst = 1'b1;
        set_cpu(1'b1, 1'b0, 32'h40, 32'h0, 4'hf); #2;
        n_cmp++; if (cpu_gnt !== 1'b1 || dbg_gnt !== 1'b0) begin n_err++; $display("FAIL mid_state_idle: got cpu=%b dbg=%b want 1/0", cpu_gnt, dbg_gnt); end
        n_cmp++; if (dbg_rvalid !== 1'b0) begin n_err++; $display("FAIL mid_no_late_rvalid: got %b want 0", dbg_rvalid); end
        @(negedge clk1);
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_dbg(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    initial begin
        rst = 1'b0;
        set_cpu(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_dbg(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) @(negedge clk1);
        test_reset;
        test_byte_enable;
        test_contention;
        test_debug_lock;
        test_starvation;
        test_alternation;
        test_reset_mid_access;
        repeat (2) @(negedge clk1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
